multicycle_cpu: RTL and testbench

//  Parametrised multi-cycle Mini-MIPS core; successor to the single-cycle cpu. Instruction memory is internal,

---
 rtl/mips_pkg.sv | 58 +++++
 rtl/mc_fsm.sv | 52 +++++
 rtl/multicycle_cpu.sv | 123 ++++++++++++
 tb/tb_multicycle_cpu.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared Mini-MIPS opcode/funct constants, FSM state and ALU encodings, instruction decoder
package mips_pkg;
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_HALT  = 6'h3F;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALTED} state_e;
    typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_e;

    typedef struct packed {
        alu_op_e alu_op;
        logic    use_imm;
        logic    wb;
        logic    dst_rd;
        logic    load;
        logic    store;
        logic    beq;
        logic    jump;
        logic    jal;
        logic    jr;
    } ctrl_t;

    // Anything not matched (unknown opcode or R-type funct) decodes to all-zero: a NOP.
    function automatic ctrl_t decode(logic [5:0] op, logic [5:0] fn);
        ctrl_t c;
        c = '0;
        case (op)
            OP_RTYPE: begin
                c.dst_rd = 1'b1;
                c.jr     = fn == FN_JR;
                c.wb     = fn inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
                c.alu_op = fn == FN_SUB ? ALU_SUB : fn == FN_AND ? ALU_AND :
                           fn == FN_OR  ? ALU_OR  : fn == FN_SLT ? ALU_SLT : ALU_ADD;
            end
            OP_ADDI: begin c.use_imm = 1'b1; c.wb = 1'b1; end
            OP_SLTI: begin c.use_imm = 1'b1; c.wb = 1'b1; c.alu_op = ALU_SLT; end
            OP_LW:   begin c.use_imm = 1'b1; c.load = 1'b1; end
            OP_SW:   begin c.use_imm = 1'b1; c.store = 1'b1; end
            OP_BEQ:  c.beq = 1'b1;
            OP_J:    c.jump = 1'b1;
            OP_JAL:  begin c.jump = 1'b1; c.jal = 1'b1; end
            default: ;
        endcase
        return c;
    endfunction
endpackage

// File: rtl/mc_fsm.sv
// mc_fsm: multi-cycle control FSM (IDLE/FETCH/DECODE/EXEC/MEM/WB/HALTED) with retire strobe
//   clk_i, rst_ni   clock, async active-low reset
//   start_i         leave IDLE/HALTED
//   halt_i/mem_i/wb_i/load_i  decoded class of the instruction in IR
//   ready_i         dmem access completes
//   state_o         current state; retire_o high on an instruction's final cycle
module mc_fsm
    import mips_pkg::*;
(
    input  logic   clk_i,
    input  logic   rst_ni,
    input  logic   start_i,
    input  logic   halt_i,
    input  logic   mem_i,
    input  logic   wb_i,
    input  logic   load_i,
    input  logic   ready_i,
    output state_e state_o,
    output logic   retire_o
);
    state_e state_q, state_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        retire_o = 1'b0;
        case (state_q)
            S_IDLE, S_HALTED: if (start_i) state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: state_d = halt_i ? S_HALTED : S_EXEC;
            S_EXEC: begin
                state_d  = mem_i ? S_MEM : wb_i ? S_WB : S_FETCH;
                retire_o = !mem_i && !wb_i;
            end
            S_MEM: if (ready_i) begin
                state_d  = load_i ? S_WB : S_FETCH;
                retire_o = !load_i;
            end
            S_WB: begin
                state_d  = S_FETCH;
                retire_o = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign state_o = state_q;
endmodule

// File: rtl/multicycle_cpu.sv
// multicycle_cpu: multi-cycle Mini-MIPS core, internal imem, external handshaked dmem
//   imem_we_i/imem_waddr_i/imem_wdata_i  imem load port, honoured only in IDLE/HALTED
//   start_i                               run from PC 0
//   dmem_*                                req/ready data port, word addresses
//   busy_o/halted_o/pc_dbg_o/instr_count_o status and debug
module multicycle_cpu
    import mips_pkg::*;
#(
    parameter int          IMEM_DEPTH = 1024,
    parameter int          DATA_W     = 32,
    parameter logic [5:0]  HALT_OP    = OP_HALT,
    localparam int         PC_W       = $clog2(IMEM_DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              imem_we_i,
    input  logic [PC_W-1:0]   imem_waddr_i,
    input  logic [31:0]       imem_wdata_i,
    input  logic              start_i,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [DATA_W-1:0] dmem_addr_o,
    output logic [DATA_W-1:0] dmem_wdata_o,
    input  logic [DATA_W-1:0] dmem_rdata_i,
    input  logic              dmem_ready_i,
    output logic              busy_o,
    output logic              halted_o,
    output logic [PC_W-1:0]   pc_dbg_o,
    output logic [31:0]       instr_count_o
);
    logic [31:0]       imem_q [IMEM_DEPTH];
    logic [DATA_W-1:0] rf_q [32];
    logic [PC_W-1:0]   pc_q, pc_inc, pc_exec;
    logic [31:0]       ir_q, count_q;
    logic [DATA_W-1:0] a_q, b_q, imm_q, alu_q, mdr_q;
    logic [DATA_W-1:0] imm_sx, alu_b, alu_y, rf_wd;
    logic [4:0]        rs, rt, rd, rf_wa;
    logic              rf_we, retire, launch, idle;
    ctrl_t             ctl;
    state_e            state;

    mc_fsm u_fsm (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .start_i (start_i),
        .halt_i  (ir_q[31:26] == HALT_OP),
        .mem_i   (ctl.load || ctl.store),
        .wb_i    (ctl.wb),
        .load_i  (ctl.load),
        .ready_i (dmem_ready_i),
        .state_o (state),
        .retire_o(retire)
    );

    assign ctl    = decode(ir_q[31:26], ir_q[5:0]);
    assign rs     = ir_q[25:21];
    assign rt     = ir_q[20:16];
    assign rd     = ir_q[15:11];
    assign imm_sx = {{(DATA_W-16){ir_q[15]}}, ir_q[15:0]};
    assign idle   = state == S_IDLE || state == S_HALTED;
    assign launch = idle && start_i;

    always_comb begin
        alu_b   = ctl.use_imm ? imm_q : b_q;
        alu_y   = ctl.alu_op == ALU_SUB ? a_q - alu_b :
                  ctl.alu_op == ALU_AND ? a_q & alu_b :
                  ctl.alu_op == ALU_OR  ? a_q | alu_b :
                  ctl.alu_op == ALU_SLT ? DATA_W'($signed(a_q) < $signed(alu_b)) : a_q + alu_b;
        // Branch/jump targets are byte addresses; bits [PC_W+1:2] give the word PC, wrapping naturally.
        pc_inc  = pc_q + PC_W'(1);
        pc_exec = ctl.jr ? a_q[PC_W+1:2] : ctl.jump ? ir_q[PC_W+1:2] :
                  (ctl.beq && a_q == b_q) ? pc_inc + imm_q[PC_W+1:2] : pc_inc;
        // jal links in EXEC; everything else writes back in WB.
        rf_we   = state == S_WB || (state == S_EXEC && ctl.jal);
        rf_wa   = ctl.jal ? 5'd31 : ctl.dst_rd ? rd : rt;
        rf_wd   = ctl.jal ? DATA_W'({pc_inc, 2'b00}) : ctl.load ? mdr_q : alu_q;
    end

    always_ff @(posedge clk_i) begin
        if (imem_we_i && idle) imem_q[imem_waddr_i] <= imem_wdata_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q    <= '0;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            imm_q   <= '0;
            alu_q   <= '0;
            mdr_q   <= '0;
            count_q <= '0;
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else begin
            if (launch) begin
                pc_q    <= '0;
                count_q <= '0;
            end
            if (state == S_FETCH) ir_q <= imem_q[pc_q];
            if (state == S_DECODE) begin
                a_q   <= rf_q[rs];
                b_q   <= rf_q[rt];
                imm_q <= imm_sx;
            end
            if (state == S_EXEC) begin
                alu_q <= alu_y;
                pc_q  <= pc_exec;
            end
            if (state == S_MEM && dmem_ready_i) mdr_q <= dmem_rdata_i;
            if (rf_we && rf_wa != 5'd0) rf_q[rf_wa] <= rf_wd;
            if (retire) count_q <= count_q + 32'd1;
        end
    end

    assign dmem_req_o    = state == S_MEM;
    assign dmem_we_o     = ctl.store;
    assign dmem_addr_o   = {2'b00, alu_q[DATA_W-1:2]};
    assign dmem_wdata_o  = b_q;
    assign busy_o        = !idle;
    assign halted_o      = state == S_HALTED;
    assign pc_dbg_o      = pc_q;
    assign instr_count_o = count_q;
endmodule

// File: tb/tb_multicycle_cpu.sv
// tb_multicycle_cpu: directed programs with a dmem scoreboard and per-run retire-timing checks
module tb_multicycle_cpu;
    localparam int PC_W = 10;
    localparam logic [5:0] ADDI = 6'h08, LW = 6'h23, SW = 6'h2B, BEQ = 6'h04, J = 6'h02, JAL = 6'h03;
    localparam logic [31:0] HALT = 32'hFC00_0000;

    logic            clk = 1'b0, rst_n = 1'b0, imem_we = 1'b0, start = 1'b0, dmem_ready = 1'b0;
    logic [PC_W-1:0] imem_waddr = '0, pc_dbg;
    logic [31:0]     imem_wdata = '0, dmem_rdata = '0, dmem_addr, dmem_wdata, instr_count;
    logic            dmem_req, dmem_we, busy, halted;

    multicycle_cpu dut (
        .clk_i(clk), .rst_ni(rst_n), .imem_we_i(imem_we), .imem_waddr_i(imem_waddr),
        .imem_wdata_i(imem_wdata), .start_i(start), .dmem_req_o(dmem_req), .dmem_we_o(dmem_we),
        .dmem_addr_o(dmem_addr), .dmem_wdata_o(dmem_wdata), .dmem_rdata_i(dmem_rdata),
        .dmem_ready_i(dmem_ready), .busy_o(busy), .halted_o(halted), .pc_dbg_o(pc_dbg),
        .instr_count_o(instr_count)
    );

    always #5 clk = ~clk;

    typedef struct {logic we; logic [31:0] addr; logic [31:0] wdata;} dacc_t;
    dacc_t       exp_q[$];
    dacc_t       r_e;
    logic [31:0] mem [256];
    int          checks = 0, errors = 0, waits = 0, r_wcnt = 0, halt_cyc, n_x;
    bit          r_acc = 0, r_have = 0;
    int          rc_q[$], rp_q[$], exp_rc[$], exp_rp[$];

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ri(logic [5:0] op, int rs, int rt, int imm);
        return {op, 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    function automatic logic [31:0] rr(int rs, int rt, int rd, logic [5:0] fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
    endfunction

    function automatic logic [31:0] jj(logic [5:0] op, int tgt);
        return {op, 26'(tgt)};
    endfunction

    // dmem slave: pops the expected access on first sight of req, checks it every held cycle,
    // answers after `waits` extra cycles.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && dmem_req === 1'b1) begin
                if (!r_acc) begin
                    r_acc  = 1;
                    r_wcnt = waits;
                    r_have = exp_q.size() != 0;
                    if (!r_have) chk("dmem_unexpected_req", 32'(dmem_req), 0);
                    else r_e = exp_q.pop_front();
                end
                if (r_have) begin
                    chk("dmem_we", 32'(dmem_we), 32'(r_e.we));
                    chk("dmem_addr", dmem_addr, r_e.addr);
                    if (r_e.we) chk("dmem_wdata", dmem_wdata, r_e.wdata);
                end
                if (r_wcnt == 0) begin
                    dmem_ready = 1;
                    dmem_rdata = mem[dmem_addr[7:0]];
                    if (dmem_we) mem[dmem_addr[7:0]] = dmem_wdata;
                    r_acc = 0;
                end else begin
                    r_wcnt--;
                    dmem_ready = 0;
                end
            end else begin
                dmem_ready = 0;
                r_acc = 0;
            end
        end
    end

    task automatic wr(int a, logic [31:0] d);
        @(negedge clk);
        imem_we = 1;
        imem_waddr = PC_W'(a);
        imem_wdata = d;
    endtask

    task automatic go();
        @(negedge clk);
        imem_we = 0;
        start = 1;
        @(negedge clk);
        start = 0;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = '0;
    endtask

    // Cycle numbers count posedges after the start edge; retire recorded when instr_count steps.
    task automatic run(int max, bit pert);
        int cyc = 0;
        logic [31:0] prev = instr_count;
        rc_q.delete();
        rp_q.delete();
        halt_cyc = -1;
        n_x = 0;
        while (cyc < max && halt_cyc < 0) begin
            @(posedge clk);
            #1;
            cyc++;
            if (pert && cyc == 2) begin imem_we = 1; imem_waddr = 1; imem_wdata = '1; end
            if (pert && cyc == 3) imem_we = 0;
            if (pert && cyc == 5) start = 1;
            if (pert && cyc == 6) start = 0;
            if ($isunknown(pc_dbg)) n_x++;
            if (instr_count != prev) begin
                rc_q.push_back(cyc);
                rp_q.push_back(int'(pc_dbg));
                prev = instr_count;
            end
            if (halted) halt_cyc = cyc;
        end
    endtask

    task automatic check_run(string tag, int hc, int cnt);
        chk({tag, "_nretire"}, rc_q.size(), exp_rc.size());
        for (int i = 0; i < exp_rc.size(); i++) begin
            chk($sformatf("%s_retire_cyc%0d", tag, i), rc_q[i], exp_rc[i]);
            chk($sformatf("%s_retire_pc%0d", tag, i), rp_q[i], exp_rp[i]);
        end
        chk({tag, "_halt_cyc"}, halt_cyc, hc);
        chk({tag, "_instr_count"}, instr_count, cnt);
        chk({tag, "_pc_known"}, n_x, 0);
        chk({tag, "_dmem_all_seen"}, exp_q.size(), 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_mem();
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_pc", 32'(pc_dbg), 0);
        chk("rst_count", instr_count, 0);
        chk("rst_req", 32'(dmem_req), 0);
        rst_n = 1;

        // Arithmetic + HALT; word 0 written in the same cycle as start.
        wr(1, ri(ADDI, 0, 2, 7));
        wr(2, rr(1, 2, 3, 6'h20));
        wr(3, HALT);
        wr(0, ri(ADDI, 0, 1, 5));
        start = 1;
        @(negedge clk);
        start = 0;
        imem_we = 0;
        exp_rc = '{4, 8, 12};
        exp_rp = '{1, 2, 3};
        run(100, 0);
        check_run("arith", 14, 3);
        chk("arith_r3", dut.rf_q[3], 12);
        chk("arith_halted", 32'(halted), 1);
        chk("arith_busy", 32'(busy), 0);

        // Store/load with two wait cycles per access; loaded from HALTED.
        wr(0, ri(ADDI, 0, 3, 12));
        wr(1, ri(SW, 0, 3, 8));
        wr(2, ri(LW, 0, 4, 8));
        wr(3, ri(SW, 0, 4, 12));
        wr(4, HALT);
        waits = 2;
        clear_mem();
        exp_q.push_back('{1'b1, 32'd2, 32'd12});
        exp_q.push_back('{1'b0, 32'd2, 32'd0});
        exp_q.push_back('{1'b1, 32'd3, 32'd12});
        exp_rc = '{4, 10, 17, 23};
        exp_rp = '{1, 2, 3, 4};
        go();
        run(100, 0);
        check_run("mem", 25, 4);
        chk("mem_r4", dut.rf_q[4], 12);

        // Re-run from HALTED while poking imem_we and start mid-program: identical behaviour.
        clear_mem();
        exp_q.push_back('{1'b1, 32'd2, 32'd12});
        exp_q.push_back('{1'b0, 32'd2, 32'd0});
        exp_q.push_back('{1'b1, 32'd3, 32'd12});
        go();
        run(100, 1);
        check_run("rerun", 25, 4);

        // Jumps: j, jal linking $31, jr back, store $31.
        @(negedge clk);
        rst_n = 0;
        @(negedge clk);
        chk("rst2_halted", 32'(halted), 0);
        chk("rst2_count", instr_count, 0);
        chk("rst2_r3", dut.rf_q[3], 0);
        rst_n = 1;
        waits = 0;
        wr(0, jj(J, 16));
        wr(4, jj(JAL, 64));
        wr(16, rr(31, 0, 0, 6'h08));
        wr(5, ri(SW, 0, 31, 0));
        wr(6, HALT);
        exp_q.push_back('{1'b1, 32'd0, 32'd20});
        exp_rc = '{3, 6, 9, 13};
        exp_rp = '{4, 16, 5, 6};
        go();
        run(100, 0);
        check_run("jump", 15, 4);
        chk("jump_r31", dut.rf_q[31], 20);

        // beq to the last word, then a NOP there wraps PC to 0.
        wr(0, ri(BEQ, 0, 0, 16'h0FF8));
        wr(1023, {6'h3E, 26'd0});
        exp_rc = '{3, 6, 9};
        exp_rp = '{1023, 0, 1023};
        go();
        run(9, 0);
        check_run("wrap", -1, 3);
        chk("wrap_busy", 32'(busy), 1);

        // Reset while a load is stalled in MEM.
        @(negedge clk);
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        waits = 1000000;
        wr(0, ri(LW, 0, 5, 4));
        exp_q.push_back('{1'b0, 32'd1, 32'd0});
        go();
        repeat (5) @(negedge clk);
        chk("stall_req", 32'(dmem_req), 1);
        chk("stall_busy", 32'(busy), 1);
        chk("stall_pc", 32'(pc_dbg), 1);
        rst_n = 0;
        #1;
        chk("arst_req", 32'(dmem_req), 0);
        chk("arst_pc", 32'(pc_dbg), 0);
        chk("arst_busy", 32'(busy), 0);
        @(posedge clk);
        #1;
        chk("arst_edge_req", 32'(dmem_req), 0);
        chk("arst_edge_busy", 32'(busy), 0);
        chk("arst_edge_pc", 32'(pc_dbg), 0);
        chk("arst_edge_count", instr_count, 0);
        chk("arst_dmem_seen", exp_q.size(), 0);
        @(negedge clk);
        rst_n = 1;
        repeat (2) @(negedge clk);
        chk("post_rst_idle", 32'(busy), 0);
        chk("post_rst_req", 32'(dmem_req), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
